// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared constants, counter encodings and mispredict causes
// Contents: PC_INC, cnt_weak_taken()/cnt_strong_taken(), mp_cause_e
package branch_predictor_pkg;
    localparam int CNT_MAX_W = 4;
    localparam int PC_INC    = 4;

    // Counter encodings depend on the counter width, so they are helper functions.
    function automatic logic [CNT_MAX_W-1:0] cnt_weak_taken(input int w);
        return CNT_MAX_W'(1) << (w - 1);
    endfunction

    function automatic logic [CNT_MAX_W-1:0] cnt_strong_taken(input int w);
        return (CNT_MAX_W'(1) << w) - CNT_MAX_W'(1);
    endfunction

    typedef enum logic [1:0] {
        MP_NONE   = 2'd0,
        MP_DIR    = 2'd1,
        MP_TARGET = 2'd2,
        MP_ALIAS  = 2'd3
    } mp_cause_e;
endpackage

// File: rtl/branch_predictor_sat_counter.sv
// sat_counter: W-bit saturating up/down counter with parallel load
// Ports: clk, rst_n (sync, active-low), load/load_val, inc, dec, q
module sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n) q <= '0;
        else if (load) q <= load_val;
        else if (inc && q != '1) q <= q + W'(1);
        else if (dec && q != '0) q <= q - W'(1);
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating direction counters
// Ports: clk, rst_n; lookup pred_pc -> pred_taken/pred_target;
//        MEM update upd_* -> mispredict/redirect_pc; flush_all;
//        perf_lookups/perf_mispredicts
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CNT_WIDTH  = 2,
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_is_branch,
    input  logic                  upd_is_uncond,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  flush_all,
    output logic [PERF_WIDTH-1:0] perf_lookups,
    output logic [PERF_WIDTH-1:0] perf_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK   = CNT_WIDTH'(cnt_weak_taken(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CNT_STRONG = CNT_WIDTH'(cnt_strong_taken(CNT_WIDTH));

    logic [ENTRIES-1:0]    valid;
    logic [ENTRIES-1:0]    uncond;
    logic [TAG_W-1:0]      tags    [ENTRIES];
    logic [ADDR_WIDTH-1:0] targets [ENTRIES];
    logic [CNT_WIDTH-1:0]  cnt     [ENTRIES];

    logic [IDX_W-1:0] idx_p, idx_u;
    logic [TAG_W-1:0] tag_p, tag_u;
    logic             hit_p, hit_u, upd_en;
    mp_cause_e        cause;

    assign idx_p = pred_pc[IDX_W+1:2];
    assign tag_p = pred_pc[ADDR_WIDTH-1:IDX_W+2];
    assign idx_u = upd_pc[IDX_W+1:2];
    assign tag_u = upd_pc[ADDR_WIDTH-1:IDX_W+2];

    assign hit_p       = valid[idx_p] && tags[idx_p] == tag_p;
    assign pred_taken  = hit_p && (uncond[idx_p] || cnt[idx_p][CNT_WIDTH-1]);
    assign pred_target = pred_taken ? targets[idx_p] : pred_pc + ADDR_WIDTH'(PC_INC);

    assign hit_u  = valid[idx_u] && tags[idx_u] == tag_u;
    assign upd_en = upd_valid && !flush_all;

    always_comb begin
        cause = MP_NONE;
        if (upd_valid) begin
            if (!upd_is_branch) cause = upd_pred_taken ? MP_ALIAS : MP_NONE;
            else if (upd_taken != upd_pred_taken) cause = MP_DIR;
            else if (upd_taken && upd_pred_target != upd_target) cause = MP_TARGET;
        end
    end

    assign mispredict  = cause != MP_NONE;
    assign redirect_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + ADDR_WIDTH'(PC_INC);

    // Jumps always load strong-taken; a conditional hit steps the counter;
    // a conditional allocation starts weakly taken.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        logic sel;
        assign sel = upd_en && upd_is_branch && idx_u == IDX_W'(i);
        sat_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (sel && (hit_u ? upd_is_uncond : upd_taken)),
            .load_val (upd_is_uncond ? CNT_STRONG : CNT_WEAK),
            .inc      (sel && hit_u && upd_taken),
            .dec      (sel && hit_u && !upd_taken),
            .q        (cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid            <= '0;
            uncond           <= '0;
            perf_lookups     <= '0;
            perf_mispredicts <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                tags[k]    <= '0;
                targets[k] <= '0;
            end
        end else begin
            if (upd_valid) begin
                perf_lookups <= perf_lookups + PERF_WIDTH'(1);
                if (mispredict) perf_mispredicts <= perf_mispredicts + PERF_WIDTH'(1);
            end
            if (flush_all) valid <= '0;
            else if (upd_valid) begin
                if (upd_is_branch && (hit_u || upd_taken)) begin
                    valid[idx_u]  <= 1'b1;
                    tags[idx_u]   <= tag_u;
                    uncond[idx_u] <= upd_is_uncond;
                    if (upd_taken) targets[idx_u] <= upd_target;
                end else if (!upd_is_branch && hit_u) begin
                    valid[idx_u] <= 1'b0;
                end
            end
        end
    end
endmodule
